// File: rtl/k052109_pkg.sv
// k052109_pkg
// Shared raster constants and small helpers for the k052109 H/V timing
// generator. The counters are 9 bits wide and wrap by explicit compare
// against CNT_WRAP; the *_DEF values are the default raster windows used as
// parameter defaults by k052109_hvcnt.
package k052109_pkg;

  localparam int CNT_W = 9;

  typedef logic [CNT_W-1:0] cnt_t;

  // Terminal count of both raster counters.
  localparam cnt_t CNT_WRAP = 9'd511;

  // Horizontal raster: 384 pixels per line (128..511).
  localparam cnt_t H_START_DEF = 9'd128;
  localparam cnt_t H_VIS_DEF   = 9'd176;
  localparam cnt_t H_BLK_DEF   = 9'd496;
  localparam cnt_t HS_END_DEF  = 9'd160;

  // Vertical raster: 264 lines per frame (248..511).
  localparam cnt_t V_START_DEF = 9'd248;
  localparam cnt_t V_VIS_DEF   = 9'd272;
  localparam cnt_t V_BLK_DEF   = 9'd496;
  localparam cnt_t VS_END_DEF  = 9'd256;

  // Half-open window test lo <= val < hi, unsigned.
  function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/k052109_wrapcnt.sv
// k052109_wrapcnt
// 9-bit raster counter. Advances by one on every clock where en is high and
// reloads LOAD_VAL instead of overflowing when it sits at CNT_WRAP. The
// next-state value is exported so the parent can decode from it and register
// its outputs on the same edge the count changes.
//
// Ports:
//   clk        counter clock
//   rst_n      asynchronous active-low reset, count returns to LOAD_VAL
//   en         advance enable
//   count      registered count
//   count_next value count takes on the next clock edge
//   wrap       high when the next edge reloads LOAD_VAL (en and count at wrap)
module k052109_wrapcnt
  import k052109_pkg::*;
#(
  parameter cnt_t LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output cnt_t count,
  output cnt_t count_next,
  output logic wrap
);

  logic at_wrap;

  assign at_wrap = (count == CNT_WRAP);
  assign wrap    = en & at_wrap;

  always_comb begin
    count_next = count;
    if (en) begin
      count_next = at_wrap ? LOAD_VAL : count + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LOAD_VAL;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/k052109_hvcnt.sv
// k052109_hvcnt
// Raster timing generator for the k052109 tile layer. Divides the 24 MHz
// master clock into a 6 MHz pixel enable, runs the 9-bit H/V counters and
// registers all blanking, sync, frame-strobe and interrupt-trigger outputs.
//
// Ports:
//   M24        master clock, rising edge
//   RES        asynchronous active-low reset
//   TEST       1 = pixel enable every M24 cycle
//   PXCE       pixel clock enable (1 of 4 M24 cycles in normal mode)
//   HCNT/VCNT  horizontal / vertical counts
//   HBLK/VBLK  horizontal / vertical blank, active high
//   HSYNCn     horizontal sync, active low
//   VSYNCn     vertical sync, active low
//   HVOT       frame-start strobe for the sprite engine
//   TRIG_IRQ   one-pixel pulse at the start of the vblank line
//   TRIG_FIRQ  one-pixel pulse every 16 lines
//   TRIG_NMI   one-pixel pulse every 32 lines
module k052109_hvcnt
  import k052109_pkg::*;
#(
  parameter cnt_t H_START = H_START_DEF,
  parameter cnt_t H_VIS   = H_VIS_DEF,
  parameter cnt_t H_BLK   = H_BLK_DEF,
  parameter cnt_t HS_END  = HS_END_DEF,
  parameter cnt_t V_START = V_START_DEF,
  parameter cnt_t V_VIS   = V_VIS_DEF,
  parameter cnt_t V_BLK   = V_BLK_DEF,
  parameter cnt_t VS_END  = VS_END_DEF
) (
  input  logic       M24,
  input  logic       RES,
  input  logic       TEST,
  output logic       PXCE,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       HBLK,
  output logic       VBLK,
  output logic       HSYNCn,
  output logic       VSYNCn,
  output logic       HVOT,
  output logic       TRIG_IRQ,
  output logic       TRIG_FIRQ,
  output logic       TRIG_NMI
);

  logic [1:0] presc;
  cnt_t       h_next;
  cnt_t       v_next;
  logic       h_wrap;
  logic       v_wrap;

  // PXCE is registered from the prescaler value about to become 3, so it is
  // high during the cycle in which the prescaler reads 3. The prescaler keeps
  // running in TEST mode so normal timing resumes cleanly afterwards.
  always_ff @(posedge M24 or negedge RES) begin
    if (!RES) begin
      presc <= 2'd0;
      PXCE  <= 1'b0;
    end else begin
      presc <= presc + 2'd1;
      PXCE  <= TEST | (presc == 2'd2);
    end
  end

  k052109_wrapcnt #(
    .LOAD_VAL (H_START)
  ) u_hcnt (
    .clk        (M24),
    .rst_n      (RES),
    .en         (PXCE),
    .count      (HCNT),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  // The vertical counter only steps on the pixel where H reloads.
  k052109_wrapcnt #(
    .LOAD_VAL (V_START)
  ) u_vcnt (
    .clk        (M24),
    .rst_n      (RES),
    .en         (h_wrap),
    .count      (VCNT),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Decodes are taken from the next-state counts so they move on the same
  // edge as HCNT/VCNT. Triggers are only raised by an actual H wrap, which
  // naturally suppresses them for the frame-start pixel that follows reset
  // (the counters sit at the start position without having wrapped into it).
  // Any later pixel edge clears them, giving a one-pixel pulse.
  always_ff @(posedge M24 or negedge RES) begin
    if (!RES) begin
      HBLK      <= 1'b1;
      VBLK      <= 1'b1;
      HSYNCn    <= 1'b0;
      VSYNCn    <= 1'b0;
      HVOT      <= 1'b0;
      TRIG_IRQ  <= 1'b0;
      TRIG_FIRQ <= 1'b0;
      TRIG_NMI  <= 1'b0;
    end else if (PXCE) begin
      HBLK      <= (h_next < H_VIS) | (h_next >= H_BLK);
      VBLK      <= (v_next < V_VIS) | (v_next >= V_BLK);
      HSYNCn    <= ~in_window(h_next, H_START, HS_END);
      VSYNCn    <= ~in_window(v_next, V_START, VS_END);
      HVOT      <= v_wrap;
      TRIG_IRQ  <= h_wrap & (v_next == V_BLK);
      TRIG_FIRQ <= h_wrap & (v_next[3:0] == 4'd0);
      TRIG_NMI  <= h_wrap & (v_next[4:0] == 5'd0);
    end
  end

endmodule
